// File: rtl/vga_sync.sv
// 640x480 VGA timing generator: pixel strobe, hc/vc counters, sync/blank decode, frame tick.
// Optional frame counter output enabled by VGA_FRAME_CNT_EN.
module vga_sync #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 521,
    parameter int unsigned H_PULSE = 96,
    parameter int unsigned V_PULSE = 2,
    parameter int unsigned HBP     = 144,
    parameter int unsigned HFP     = 784,
    parameter int unsigned VBP     = 31,
    parameter int unsigned VFP     = 511
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
   ,output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_PW    = 10'(H_PULSE);
    localparam logic [9:0] V_PW    = 10'(V_PULSE);
    localparam logic [9:0] H_VIS_S = 10'(HBP);
    localparam logic [9:0] H_VIS_E = 10'(HFP);
    localparam logic [9:0] V_VIS_S = 10'(VBP);
    localparam logic [9:0] V_VIS_E = 10'(VFP);
    localparam logic [9:0] V_TICK  = 10'(VFP - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       hc_q, hc_d;
    logic [9:0]       vc_q, vc_d;
    logic             frame_tick_q, frame_tick_d;
    logic             pix_en_w;
    logic             line_end;

    // With CLK_DIV=1 DIV_LAST is 0, so the strobe is permanently high.
    assign pix_en_w = (div_cnt_q == DIV_LAST);
    assign line_end = (hc_q == H_LAST);

    always_comb begin
        div_cnt_d    = pix_en_w ? '0 : div_cnt_q + 1'b1;
        hc_d         = hc_q;
        vc_d         = vc_q;
        frame_tick_d = 1'b0;
        if (pix_en_w) begin
            if (line_end) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
                frame_tick_d = (vc_q == V_TICK);
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            hc_q         <= '0;
            vc_q         <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            hc_q         <= hc_d;
            vc_q         <= vc_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick_d) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign pix_en     = pix_en_w;
    assign hc         = hc_q;
    assign vc         = vc_q;
    assign hsync      = ~(hc_q < H_PW);
    assign vsync      = ~(vc_q < V_PW);
    assign video_on   = (hc_q >= H_VIS_S) && (hc_q < H_VIS_E) &&
                        (vc_q >= V_VIS_S) && (vc_q < V_VIS_E);
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: full-size instance for strobe/line/reset, scaled CLK_DIV=1 instance for frame behaviour.
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n;
    logic       pix_en_a, hsync_a, vsync_a, video_on_a, frame_tick_a;
    logic [9:0] hc_a, vc_a;
    logic       pix_en_b, hsync_b, vsync_b, video_on_b, frame_tick_b;
    logic [9:0] hc_b, vc_b;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    vga_sync u_dut_a (
        .clk        (clk),
        .rst_n      (rst_a_n),
        .pix_en     (pix_en_a),
        .hc         (hc_a),
        .vc         (vc_a),
        .hsync      (hsync_a),
        .vsync      (vsync_a),
        .video_on   (video_on_a),
        .frame_tick (frame_tick_a)
`ifdef VGA_FRAME_CNT_EN
       ,.frame_cnt  (frame_cnt_a)
`endif
    );

    // Scaled timing: 20 px/line, 12 lines/frame, frame = 240 clks.
    vga_sync #(
        .CLK_DIV (1), .H_TOTAL (20), .V_TOTAL (12), .H_PULSE (3), .V_PULSE (2),
        .HBP (5), .HFP (17), .VBP (3), .VFP (10)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_b_n),
        .pix_en     (pix_en_b),
        .hc         (hc_b),
        .vc         (vc_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .video_on   (video_on_b),
        .frame_tick (frame_tick_b)
`ifdef VGA_FRAME_CNT_EN
       ,.frame_cnt  (frame_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int hs_low, hc_max, tick_cnt, first_tick, second_tick, vs_low, pix_low;

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        tick(2);
        check("rst_hc", 32'(hc_a), 0);
        check("rst_vc", 32'(vc_a), 0);
        check("rst_hsync", 32'(hsync_a), 0);
        check("rst_vsync", 32'(vsync_a), 0);
        check("rst_video_on", 32'(video_on_a), 0);
        check("rst_pix_en", 32'(pix_en_a), 0);
        check("rst_frame_tick", 32'(frame_tick_a), 0);
`ifdef VGA_FRAME_CNT_EN
        check("rst_frame_cnt", 32'(frame_cnt_a), 0);
`endif

        // Strobe phase: high after edges 3, 7, 11 from release.
        rst_a_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check($sformatf("pix_en_k%0d", k), 32'(pix_en_a), (k % 4 == 3) ? 1 : 0);
            if (k == 4) check("hc_after_4", 32'(hc_a), 1);
        end

        // One full line from a fresh reset.
        rst_a_n = 1'b0;
        tick(1);
        rst_a_n = 1'b1;
        hs_low = 0;
        hc_max = 0;
        for (int k = 0; k < 3200; k++) begin
            if (!hsync_a) hs_low++;
            if (int'(hc_a) > hc_max) hc_max = int'(hc_a);
            if (k == 383) check("hsync_last_low", 32'(hsync_a), 0);
            if (k == 384) check("hsync_first_high", 32'(hsync_a), 1);
            tick(1);
        end
        check("hsync_low_clks", 32'(hs_low), 384);
        check("line_hc_max", 32'(hc_max), 799);
        check("line_hc_wrap", 32'(hc_a), 0);
        check("line_vc_inc", 32'(vc_a), 1);

        // Mid-line reset.
        tick(1600);
        check("pre_rst_hc", 32'(hc_a), 400);
        rst_a_n = 1'b0;
        tick(1);
        check("midrst_hc", 32'(hc_a), 0);
        check("midrst_vc", 32'(vc_a), 0);
        check("midrst_tick", 32'(frame_tick_a), 0);
        check("midrst_pix_en", 32'(pix_en_a), 0);
        rst_a_n = 1'b1;
        tick(4);
        check("resume_hc", 32'(hc_a), 1);

        // Scaled instance: hc = k%20, vc = (k/20)%12, ticks at k = 200, 440, 680.
        rst_b_n = 1'b1;
        tick_cnt = 0; first_tick = -1; second_tick = -1; vs_low = 0; pix_low = 0;
        for (int k = 0; k < 720; k++) begin
            if (!pix_en_b) pix_low++;
            if (k < 240 && !vsync_b) vs_low++;
            if (frame_tick_b) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = k;
                else if (second_tick < 0) second_tick = k;
                check($sformatf("tick_hc_k%0d", k), 32'(hc_b), 0);
                check($sformatf("tick_vc_k%0d", k), 32'(vc_b), 10);
`ifdef VGA_FRAME_CNT_EN
                check($sformatf("frame_cnt_k%0d", k), 32'(frame_cnt_b), 32'(tick_cnt));
`endif
            end
            case (k)
                65:  check("vid_5_3", 32'(video_on_b), 1);
                196: check("vid_16_9", 32'(video_on_b), 1);
                64:  check("vid_4_3", 32'(video_on_b), 0);
                117: check("vid_17_5", 32'(video_on_b), 0);
                48:  check("vid_8_2", 32'(video_on_b), 0);
                208: check("vid_8_10", 32'(video_on_b), 0);
                239: begin
                    check("prewrap_hc", 32'(hc_b), 19);
                    check("prewrap_vc", 32'(vc_b), 11);
                end
                240: begin
                    check("wrap_hc", 32'(hc_b), 0);
                    check("wrap_vc", 32'(vc_b), 0);
                end
                default: ;
            endcase
            tick(1);
        end
        check("tick_count", 32'(tick_cnt), 3);
        check("first_tick_k", 32'(first_tick), 200);
        check("tick_period", 32'(second_tick - first_tick), 240);
        check("vsync_low_clks", 32'(vs_low), 40);
        check("pix_en_div1_low", 32'(pix_low), 0);

        tick(150);
        check("b_pre_rst_hc", 32'(hc_b), 10);
        check("b_pre_rst_vc", 32'(vc_b), 7);
        rst_b_n = 1'b0;
        tick(1);
        check("b_midrst_hc", 32'(hc_b), 0);
        check("b_midrst_vc", 32'(vc_b), 0);
        check("b_midrst_pix_en", 32'(pix_en_b), 1);
`ifdef VGA_FRAME_CNT_EN
        check("b_midrst_frame_cnt", 32'(frame_cnt_b), 0);
`endif
        rst_b_n = 1'b1;
        tick(20);
        check("b_resume_hc", 32'(hc_b), 0);
        check("b_resume_vc", 32'(vc_b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
